// File: rtl/drink_pkg.sv
// Shared definitions for the drink fill controller.
//   SIZE_SMALL / SIZE_LARGE : request size codes
//   state_e                 : controller FSM states
//   eff_cycles()            : maps a cycle-count parameter of 0 to 1
//   size_valid()            : true for a recognised size code
package drink_pkg;

  localparam logic [1:0] SIZE_SMALL = 2'b01;
  localparam logic [1:0] SIZE_LARGE = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CUP,
    ICE,
    POUR,
    FIN,
    ERR
  } state_e;

  function automatic int unsigned eff_cycles(input int unsigned cycles);
    return (cycles == 0) ? 1 : cycles;
  endfunction

  function automatic logic size_valid(input logic [1:0] size);
    return (size == SIZE_SMALL) || (size == SIZE_LARGE);
  endfunction

endpackage

// File: rtl/drink_dispense_ctrl_if.sv
// Fill-request channel between the drink-selection FSMs (master) and the
// dispense controller (slave).
//   req_valid  master->slave  request present
//   req_size   master->slave  01 small, 10 large, others invalid
//   req_ready  slave->master  controller idle; transfer = req_valid & req_ready
//   busy       slave->master  controller not idle
//   done       slave->master  1-cycle pulse, pour completed
//   err        slave->master  1-cycle pulse, request aborted
interface drink_dispense_ctrl_if;
  logic       req_valid;
  logic [1:0] req_size;
  logic       req_ready;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output req_valid, req_size,
    input  req_ready, busy, done, err
  );

  modport slave (
    input  req_valid, req_size,
    output req_ready, busy, done, err
  );
endinterface

// File: rtl/dispense_timer.sv
// Loadable up/down counter shared by the wait, ice and pour phases.
// Saturates at 0 when counting down and at all-ones when counting up.
//   clk, reset : clock, async active-high reset (count -> 0)
//   load       : load load_val (highest priority)
//   load_val   : value to load
//   dec / inc  : count down / up (dec wins over inc)
//   count      : current value
//   zero       : count == 0
module dispense_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      if (count != '0) count <= count - 1'b1;
    end else if (inc) begin
      if (count != '1) count <= count + 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/drink_dispense_ctrl.sv
// Drink fill controller: accepts a cup-size request, waits for a cup, optionally
// gates ice, then holds the pour valve open for a size-dependent number of cycles.
// Optional feature macro: ICE_DISPENSE_EN (adds the ICE phase and ice_open port).
//   clk, reset   : clock, async active-high reset
//   req          : fill-request channel (slave side)
//   cup_present  : cup sensor, synchronous to clk
//   valve_open   : pour valve drive
//   ice_open     : ice gate drive (ICE_DISPENSE_EN only)
module drink_dispense_ctrl
  import drink_pkg::*;
#(
  parameter int unsigned SMALL_CYCLES = 5,
  parameter int unsigned LARGE_CYCLES = 8,
  parameter int unsigned WAIT_TIMEOUT = 16,
  parameter int unsigned ICE_CYCLES   = 3,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  drink_dispense_ctrl_if.slave  req,
  input  logic                  cup_present,
  output logic                  valve_open
`ifdef ICE_DISPENSE_EN
  ,
  output logic                  ice_open
`endif
);

  // Counter reload values are "cycles - 1" since the phase ends on the zero cycle.
  localparam logic [CNT_W-1:0] SMALL_LAST   = CNT_W'(eff_cycles(SMALL_CYCLES) - 1);
  localparam logic [CNT_W-1:0] LARGE_LAST   = CNT_W'(eff_cycles(LARGE_CYCLES) - 1);
  localparam logic [CNT_W-1:0] ICE_LAST     = CNT_W'(eff_cycles(ICE_CYCLES) - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(eff_cycles(WAIT_TIMEOUT) - 1);

`ifdef ICE_DISPENSE_EN
  localparam bit ICE_EN = 1'b1;
`else
  localparam bit ICE_EN = 1'b0;
`endif

  state_e           state, state_nxt;
  logic [1:0]       size_q;
  logic             ready_q, busy_q, done_q, err_q, valve_q;
  logic [CNT_W-1:0] pour_last;
  logic [CNT_W-1:0] count;
  logic             cnt_zero, cnt_load, cnt_inc, cnt_dec;
  logic [CNT_W-1:0] cnt_load_val;

  assign pour_last = (size_q == SIZE_LARGE) ? LARGE_LAST : SMALL_LAST;

  always_comb begin
    state_nxt    = state;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_inc      = 1'b0;
    cnt_dec      = 1'b0;
    unique case (state)
      IDLE: begin
        if (req.req_valid) begin
          cnt_load  = 1'b1;  // restart the cup-wait count from 0
          state_nxt = size_valid(req.req_size) ? WAIT_CUP : ERR;
        end
      end
      WAIT_CUP: begin
        // A cup arriving on the last wait cycle still wins over the timeout.
        if (cup_present) begin
          cnt_load = 1'b1;
          if (ICE_EN) begin
            cnt_load_val = ICE_LAST;
            state_nxt    = ICE;
          end else begin
            cnt_load_val = pour_last;
            state_nxt    = POUR;
          end
        end else if (count == TIMEOUT_LAST) begin
          state_nxt = ERR;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ICE: begin
        if (!cup_present) begin
          state_nxt = ERR;
        end else if (cnt_zero) begin
          cnt_load     = 1'b1;
          cnt_load_val = pour_last;
          state_nxt    = POUR;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      POUR: begin
        if (!cup_present) begin
          state_nxt = ERR;  // cup removal beats completion
        end else if (cnt_zero) begin
          state_nxt = FIN;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      FIN, ERR: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they match a state decode
  // while still being cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      size_q  <= 2'b00;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      valve_q <= 1'b0;
`ifdef ICE_DISPENSE_EN
      ice_open <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && req.req_valid && size_valid(req.req_size)) begin
        size_q <= req.req_size;
      end
      ready_q <= (state_nxt == IDLE);
      busy_q  <= (state_nxt != IDLE);
      done_q  <= (state_nxt == FIN);
      err_q   <= (state_nxt == ERR);
      valve_q <= (state_nxt == POUR);
`ifdef ICE_DISPENSE_EN
      ice_open <= (state_nxt == ICE);
`endif
    end
  end

  assign req.req_ready = ready_q;
  assign req.busy      = busy_q;
  assign req.done      = done_q;
  assign req.err       = err_q;
  assign valve_open    = valve_q;

  dispense_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .inc      (cnt_inc),
    .dec      (cnt_dec),
    .count    (count),
    .zero     (cnt_zero)
  );

endmodule

// File: tb/tb_drink_dispense_ctrl.sv
// Directed bench for drink_dispense_ctrl. Inputs change and outputs are sampled
// on the falling clock edge. Index 0 of a transaction is the first sample after
// the accepting rising edge.
module tb_drink_dispense_ctrl;

`ifdef ICE_DISPENSE_EN
  localparam int ICE_LAT = 3;
`else
  localparam int ICE_LAT = 0;
`endif

  logic clk;
  logic reset;
  logic cup_present;
  logic valve_open;
`ifdef ICE_DISPENSE_EN
  logic ice_open;
`endif

  drink_dispense_ctrl_if bus ();

  drink_dispense_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .req         (bus.slave),
    .cup_present (cup_present),
    .valve_open  (valve_open)
`ifdef ICE_DISPENSE_EN
    ,
    .ice_open    (ice_open)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-transaction observations.
  int r_valve, r_first, r_last, r_busy, r_done, r_err, r_done_at, r_err_at, r_idle_at, r_ice;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // Issues one request and watches until the controller returns to idle.
  // cup_on/cup_off: index at which the cup sensor is raised/lowered (-1 = never).
  task automatic run_txn(input logic [1:0] size, input int cup_on, input int cup_off);
    r_valve = 0; r_first = -1; r_last = -1; r_busy = 0; r_done = 0; r_err = 0;
    r_done_at = -1; r_err_at = -1; r_idle_at = -1; r_ice = 0;
    bus.req_valid = 1'b1;
    bus.req_size  = size;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.req_ready) begin
        r_idle_at = i;
        break;
      end
      if (valve_open) begin
        if (r_first < 0) r_first = i;
        r_last = i;
        r_valve++;
      end
`ifdef ICE_DISPENSE_EN
      if (ice_open) r_ice++;
`endif
      if (bus.busy) r_busy++;
      if (bus.done) begin r_done++; r_done_at = i; end
      if (bus.err)  begin r_err++;  r_err_at  = i; end
      if (i == cup_on)  cup_present = 1'b1;
      if (i == cup_off) cup_present = 1'b0;
    end
    check_eq("idle_reached", 32'(r_idle_at >= 0), 32'd1);
  endtask

  initial begin
    reset         = 1'b1;
    cup_present   = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_size  = 2'b00;
    #1;
    check_eq("rst_ready", 32'(bus.req_ready), 32'd1);
    check_eq("rst_busy",  32'(bus.busy),      32'd0);
    check_eq("rst_valve", 32'(valve_open),    32'd0);
    check_eq("rst_done",  32'(bus.done),      32'd0);
    check_eq("rst_err",   32'(bus.err),       32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 1: small pour with cup already present
    cup_present = 1'b1;
    run_txn(2'b01, -1, -1);
    check_eq("t1_first_valve", r_first,   1 + ICE_LAT);
    check_eq("t1_valve_cnt",   r_valve,   5);
    check_eq("t1_contiguous",  r_last - r_first + 1, 5);
    check_eq("t1_done_cnt",    r_done,    1);
    check_eq("t1_done_at",     r_done_at, r_last + 1);
    check_eq("t1_err_cnt",     r_err,     0);
    check_eq("t1_busy_cnt",    r_busy,    7 + ICE_LAT);
`ifdef ICE_DISPENSE_EN
    check_eq("t1_ice_cnt",     r_ice,     3);
`endif

    // 2: large pour, issued back-to-back on the first idle cycle after done
    run_txn(2'b10, -1, -1);
    check_eq("t2_valve_cnt", r_valve,   8);
    check_eq("t2_done_cnt",  r_done,    1);
    check_eq("t2_done_at",   r_done_at, 9 + ICE_LAT);
    check_eq("t2_idle_at",   r_idle_at, r_done_at + 1);

    // 3: cup lifted during the third pour cycle
    run_txn(2'b01, -1, 3 + ICE_LAT);
    check_eq("t3_valve_cnt", r_valve,  3);
    check_eq("t3_err_at",    r_err_at, 4 + ICE_LAT);
    check_eq("t3_err_cnt",   r_err,    1);
    check_eq("t3_done_cnt",  r_done,   0);

    // 4: no cup ever -> timeout
    cup_present = 1'b0;
    run_txn(2'b10, -1, -1);
    check_eq("t4_err_at",    r_err_at, 16);
    check_eq("t4_err_cnt",   r_err,    1);
    check_eq("t4_valve_cnt", r_valve,  0);
    check_eq("t4_done_cnt",  r_done,   0);

    // 5: invalid size code
    run_txn(2'b11, -1, -1);
    check_eq("t5_err_at",    r_err_at, 0);
    check_eq("t5_busy_cnt",  r_busy,   1);
    check_eq("t5_valve_cnt", r_valve,  0);
    run_txn(2'b00, -1, -1);
    check_eq("t5b_err_at",   r_err_at, 0);

    // 7: cup arrives late; the latched small size must still be used
    run_txn(2'b01, 5, -1);
    check_eq("t7_first_valve", r_first, 6 + ICE_LAT);
    check_eq("t7_valve_cnt",   r_valve, 5);
    check_eq("t7_done_cnt",    r_done,  1);
    cup_present = 1'b0;

    // 8: cup arrives on the last wait cycle; cup beats timeout
    run_txn(2'b01, 15, -1);
    check_eq("t8_err_cnt",     r_err,   0);
    check_eq("t8_first_valve", r_first, 16 + ICE_LAT);
    check_eq("t8_valve_cnt",   r_valve, 5);
    cup_present = 1'b0;

    // 6: asynchronous reset while pouring
    cup_present   = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_size  = 2'b01;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2 + ICE_LAT) @(negedge clk);
    check_eq("t6_valve_before", 32'(valve_open), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("t6_valve_async", 32'(valve_open),    32'd0);
    check_eq("t6_busy_async",  32'(bus.busy),      32'd0);
    check_eq("t6_ready_async", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("t6_ready_after", 32'(bus.req_ready), 32'd1);
    check_eq("t6_done_after",  32'(bus.done),      32'd0);
    check_eq("t6_err_after",   32'(bus.err),       32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
